// File: rtl/axi_err_responder.sv
`default_nettype none
// ============================================================================
// Module      : axi_err_responder (+ axi_err_responder_fifo helper)
// Description : Terminating AXI4+ATOP subordinate. Accepts every AW/W/AR
//               request and answers it with SLVERR without touching memory.
//               Write data is absorbed. Each write burst produces one B.
//               Each read, and each atomic that carries an R response,
//               produces len+1 R beats.
// Revision    : 1.0 - initial release
// ============================================================================

// Small synchronous FIFO. It has one write port and one read port.
// The read data is forced to zero while the FIFO is empty, so the head
// value seen downstream is well defined after reset.
module axi_err_responder_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  // A push on a full FIFO is refused even when a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy tracking. Reset drops every queued entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array. No reset is needed because the output is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

module axi_err_responder #(
  parameter int IdWidth   = 4,
  parameter int DataWidth = 64,
  parameter int MaxTxns   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic [7:0]           aw_len_i,
  input  logic [5:0]           aw_atop_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic                 w_last_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [7:0]           ar_len_i,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  output logic                 r_valid_o,
  input  logic                 r_ready_i
);
  localparam logic [1:0] RESP_SLVERR      = 2'b10;
  localparam logic [1:0] ATOP_ATOMICSTORE = 2'b01;
  localparam int         R_W              = IdWidth + 8;

  logic               aw_needs_r;
  logic               aw_full, aw_empty, b_full, b_empty, r_full, r_empty;
  logic               aw_hs, w_last_hs, b_hs, ar_hs, r_hs;
  logic               atomic_r_push, r_push;
  logic [IdWidth-1:0] aw_head_id;
  logic [R_W-1:0]     r_push_data;
  logic [R_W-1:0]     r_head;
  logic [IdWidth-1:0] r_head_id;
  logic [7:0]         r_head_len;
  logic [7:0]         beat_cnt;

  // Every atomic except AtomicStore returns data, so it needs an R burst.
  assign aw_needs_r = (aw_atop_i != 6'd0) && (aw_atop_i[5:4] != ATOP_ATOMICSTORE);

  // Readiness comes only from FIFO state, and from the atomic class for AW.
  // AR yields to an atomic AW on the single R FIFO write port.
  assign aw_ready_o = !rst_i && !aw_full && (!aw_needs_r || !r_full);
  assign w_ready_o  = !rst_i && !aw_empty && (!w_last_i || !b_full);
  assign ar_ready_o = !rst_i && !r_full && !(aw_valid_i && aw_ready_o && aw_needs_r);

  assign aw_hs         = aw_valid_i && aw_ready_o;
  assign w_last_hs     = w_valid_i && w_ready_o && w_last_i;
  assign b_hs          = b_valid_o && b_ready_i;
  assign ar_hs         = ar_valid_i && ar_ready_o;
  assign r_hs          = r_valid_o && r_ready_i;
  assign atomic_r_push = aw_hs && aw_needs_r;
  assign r_push        = atomic_r_push || ar_hs;
  assign r_push_data   = atomic_r_push ? {aw_id_i, aw_len_i} : {ar_id_i, ar_len_i};

  // Write IDs that are waiting for the last beat of their W burst.
  axi_err_responder_fifo #(.WIDTH(IdWidth), .DEPTH(MaxTxns)) u_aw_fifo (
    .clk(clk_i), .rst(rst_i), .push(aw_hs), .wdata(aw_id_i), .pop(w_last_hs),
    .rdata(aw_head_id), .full(aw_full), .empty(aw_empty)
  );

  // Completed write bursts that are waiting for their B response.
  axi_err_responder_fifo #(.WIDTH(IdWidth), .DEPTH(MaxTxns)) u_b_fifo (
    .clk(clk_i), .rst(rst_i), .push(w_last_hs), .wdata(aw_head_id), .pop(b_hs),
    .rdata(b_id_o), .full(b_full), .empty(b_empty)
  );

  // Read and atomic bursts that are waiting for R beats, kept in push order.
  axi_err_responder_fifo #(.WIDTH(R_W), .DEPTH(MaxTxns)) u_r_fifo (
    .clk(clk_i), .rst(rst_i), .push(r_push), .wdata(r_push_data),
    .pop(r_hs && r_last_o), .rdata(r_head), .full(r_full), .empty(r_empty)
  );

  assign {r_head_id, r_head_len} = r_head;

  assign b_valid_o = !b_empty;
  assign b_resp_o  = RESP_SLVERR;
  assign r_valid_o = !r_empty;
  assign r_id_o    = r_head_id;
  assign r_data_o  = '0;
  assign r_resp_o  = RESP_SLVERR;
  assign r_last_o  = r_valid_o && (beat_cnt == r_head_len);

  // Beat index within the head R burst. It restarts after the final beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_cnt <= '0;
    end else if (r_hs) begin
      beat_cnt <= r_last_o ? '0 : beat_cnt + 8'd1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_axi_err_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_err_responder
// Description : Scoreboard bench for axi_err_responder. A cycle-based driver
//               checks the ready signals against a transaction-level model
//               and queues the expected B/R responses. A separate monitor
//               compares every presented response against the queues.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_axi_err_responder;
  localparam int IDW  = 4;
  localparam int DW   = 64;
  localparam int MAXT = 8;

  logic           clk = 1'b0;
  logic           rst_i;
  logic [IDW-1:0] aw_id_i;
  logic [7:0]     aw_len_i;
  logic [5:0]     aw_atop_i;
  logic           aw_valid_i, aw_ready_o;
  logic           w_last_i, w_valid_i, w_ready_o;
  logic [IDW-1:0] b_id_o;
  logic [1:0]     b_resp_o;
  logic           b_valid_o, b_ready_i;
  logic [IDW-1:0] ar_id_i;
  logic [7:0]     ar_len_i;
  logic           ar_valid_i, ar_ready_o;
  logic [IDW-1:0] r_id_o;
  logic [DW-1:0]  r_data_o;
  logic [1:0]     r_resp_o;
  logic           r_last_o, r_valid_o, r_ready_i;

  axi_err_responder #(.IdWidth(IDW), .DataWidth(DW), .MaxTxns(MAXT)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .aw_id_i(aw_id_i), .aw_len_i(aw_len_i), .aw_atop_i(aw_atop_i),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
    .w_last_i(w_last_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
    .b_id_o(b_id_o), .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
    .ar_id_i(ar_id_i), .ar_len_i(ar_len_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
    .r_id_o(r_id_o), .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic [IDW-1:0] id; logic [7:0] len; } aw_t;
  typedef struct { logic [IDW-1:0] id; logic last; } rbeat_t;

  aw_t            pend[$];   // accepted writes still waiting for their W last beat
  logic [IDW-1:0] b_exp[$];  // expected B ids, oldest first
  rbeat_t         r_exp[$];  // expected R beats, oldest first
  int             r_occ;     // R bursts accepted but not yet fully returned
  int             wbeat;
  int             n_cmp = 0;
  int             n_err = 0;
  bit             last_aw_hs, last_w_hs, last_ar_hs;

  function automatic bit needs_r(logic [5:0] atop);
    return (atop != 6'd0) && (atop[5:4] != 2'b01);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_burst(logic [IDW-1:0] id, logic [7:0] len);
    for (int i = 0; i <= int'(len); i++) r_exp.push_back('{id: id, last: (i == int'(len))});
    r_occ++;
  endtask

  // Checks the readies for the inputs now driven, then commits the model at the edge.
  task automatic cycle();
    bit nr, e_aw, e_w, e_ar, aw_hs, w_hs, ar_hs;
    @(negedge clk);
    nr   = needs_r(aw_atop_i);
    e_aw = (pend.size() < MAXT) && (!nr || r_occ < MAXT);
    e_w  = (pend.size() > 0) && (!w_last_i || b_exp.size() < MAXT);
    e_ar = (r_occ < MAXT) && !(aw_valid_i && e_aw && nr);
    chk("aw_ready", 64'(aw_ready_o), 64'(e_aw));
    chk("w_ready", 64'(w_ready_o), 64'(e_w));
    chk("ar_ready", 64'(ar_ready_o), 64'(e_ar));
    aw_hs = aw_valid_i && aw_ready_o;
    w_hs  = w_valid_i && w_ready_o;
    ar_hs = ar_valid_i && ar_ready_o;
    @(posedge clk);
    if (w_hs && w_last_i && pend.size() > 0) begin
      b_exp.push_back(pend[0].id);
      void'(pend.pop_front());
    end
    if (w_hs) wbeat = w_last_i ? 0 : wbeat + 1;
    if (aw_hs) begin
      pend.push_back('{id: aw_id_i, len: aw_len_i});
      if (nr) push_burst(aw_id_i, aw_len_i);
    end
    if (ar_hs) push_burst(ar_id_i, ar_len_i);
    last_aw_hs = aw_hs;
    last_w_hs  = w_hs;
    last_ar_hs = ar_hs;
    #1;
  endtask

  task automatic do_reset();
    aw_valid_i = 0; w_valid_i = 0; w_last_i = 0; ar_valid_i = 0;
    rst_i = 1;
    pend.delete(); b_exp.delete(); r_exp.delete();
    r_occ = 0; wbeat = 0;
    @(negedge clk);
    chk("rst_aw_ready", 64'(aw_ready_o), 0);
    chk("rst_w_ready", 64'(w_ready_o), 0);
    chk("rst_ar_ready", 64'(ar_ready_o), 0);
    chk("rst_b_valid", 64'(b_valid_o), 0);
    chk("rst_r_valid", 64'(r_valid_o), 0);
    chk("rst_r_last", 64'(r_last_o), 0);
    chk("rst_ids", {56'd0, b_id_o, r_id_o}, 0);
    chk("rst_r_data", r_data_o, 0);
    chk("rst_resps", {60'd0, b_resp_o, r_resp_o}, 64'hA);
    @(posedge clk); #1;
    rst_i = 0;
  endtask

  task automatic send_aw(logic [IDW-1:0] id, logic [7:0] len, logic [5:0] atop);
    int t = 0;
    aw_valid_i = 1; aw_id_i = id; aw_len_i = len; aw_atop_i = atop;
    do begin cycle(); t++; end while (!last_aw_hs && t < 300);
    chk("aw_accept_timeout", 64'(last_aw_hs), 1);
    aw_valid_i = 0;
  endtask

  task automatic send_ar(logic [IDW-1:0] id, logic [7:0] len);
    int t = 0;
    ar_valid_i = 1; ar_id_i = id; ar_len_i = len;
    do begin cycle(); t++; end while (!last_ar_hs && t < 300);
    chk("ar_accept_timeout", 64'(last_ar_hs), 1);
    ar_valid_i = 0;
  endtask

  task automatic send_w(int beats);
    for (int i = 0; i < beats; i++) begin
      int t = 0;
      w_valid_i = 1; w_last_i = (i == beats - 1);
      do begin cycle(); t++; end while (!last_w_hs && t < 300);
      chk("w_accept_timeout", 64'(last_w_hs), 1);
    end
    w_valid_i = 0; w_last_i = 0;
  endtask

  task automatic drain(int bound);
    int t = 0;
    b_ready_i = 1; r_ready_i = 1;
    while ((r_exp.size() != 0 || b_exp.size() != 0) && t < bound) begin cycle(); t++; end
    chk("drain_empty", 64'(r_exp.size() + b_exp.size()), 0);
  endtask

  // Monitor: compares every presented response against the head of its queue.
  initial begin
    forever begin
      @(negedge clk); #1;
      chk("r_valid", 64'(r_valid_o), 64'(r_exp.size() != 0));
      if (r_valid_o && r_exp.size() != 0) begin
        chk("r_id", 64'(r_id_o), 64'(r_exp[0].id));
        chk("r_last", 64'(r_last_o), 64'(r_exp[0].last));
        chk("r_data", r_data_o, 0);
        chk("r_resp", 64'(r_resp_o), 64'h2);
        if (r_ready_i) begin
          if (r_exp[0].last) r_occ--;
          void'(r_exp.pop_front());
        end
      end
      chk("b_valid", 64'(b_valid_o), 64'(b_exp.size() != 0));
      if (b_valid_o && b_exp.size() != 0) begin
        chk("b_id", 64'(b_id_o), 64'(b_exp[0]));
        chk("b_resp", 64'(b_resp_o), 64'h2);
        if (b_ready_i) void'(b_exp.pop_front());
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1; aw_valid_i = 0; aw_id_i = 0; aw_len_i = 0; aw_atop_i = 0;
    w_valid_i = 0; w_last_i = 0; ar_valid_i = 0; ar_id_i = 0; ar_len_i = 0;
    b_ready_i = 0; r_ready_i = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Reset in the middle of a read burst: remaining beats are dropped.
    send_ar(4'd5, 8'd3);
    r_ready_i = 1;
    cycle(); cycle();
    do_reset();
    repeat (4) cycle();

    // Plain read of four beats.
    send_ar(4'd5, 8'd3);
    drain(50);

    // W before AW is refused. Then a plain write returns only B.
    w_valid_i = 1; w_last_i = 0;
    cycle();
    w_valid_i = 0;
    send_aw(4'd2, 8'd1, 6'b000000);
    send_w(2);
    drain(50);

    // AtomicLoad and AR in the same cycle: AW wins the R FIFO, so AR waits.
    aw_valid_i = 1; aw_id_i = 4'd3; aw_len_i = 8'd0; aw_atop_i = 6'b100000;
    ar_valid_i = 1; ar_id_i = 4'd4; ar_len_i = 8'd0;
    for (int t = 0; t < 50 && (aw_valid_i || ar_valid_i); t++) begin
      cycle();
      if (last_aw_hs) aw_valid_i = 0;
      if (last_ar_hs) ar_valid_i = 0;
    end
    chk("atomic_ar_both_accepted", {62'd0, aw_valid_i, ar_valid_i}, 0);
    send_w(1);
    drain(50);

    // AtomicStore: B only, no R.
    send_aw(4'd1, 8'd0, 6'b010000);
    send_w(1);
    drain(50);

    // Backpressure: eight reads fill the R FIFO, and the ninth waits for a drain.
    r_ready_i = 0; b_ready_i = 0;
    for (int i = 0; i < MAXT; i++) send_ar(4'(i), 8'd0);
    ar_valid_i = 1; ar_id_i = 4'd9; ar_len_i = 8'd0;
    repeat (3) cycle();
    chk("ar9_blocked", 64'(last_ar_hs), 0);
    r_ready_i = 1;
    send_ar(4'd9, 8'd0);
    drain(100);

    // Random traffic. Response readiness changes by phase so the FIFOs fill.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int phase = (cyc / 300) % 3;
      aw_valid_i = ($urandom_range(0, 2) == 0);
      aw_id_i    = 4'($urandom_range(0, 15));
      aw_len_i   = ($urandom_range(0, 29) == 0) ? 8'd255 : 8'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       aw_atop_i = 6'd0;
        1:       aw_atop_i = {2'b01, 4'($urandom_range(0, 15))};
        2:       aw_atop_i = {2'b10, 4'($urandom_range(0, 15))};
        default: aw_atop_i = {5'b11000, 1'($urandom_range(0, 1))};
      endcase
      w_valid_i  = ($urandom_range(0, 1) == 1);
      w_last_i   = (pend.size() > 0) ? (wbeat == int'(pend[0].len)) : 1'($urandom_range(0, 1));
      ar_valid_i = ($urandom_range(0, 2) == 0);
      ar_id_i    = 4'($urandom_range(0, 15));
      ar_len_i   = ($urandom_range(0, 29) == 0) ? 8'd255 : 8'($urandom_range(0, 3));
      b_ready_i  = (phase == 0) || (phase == 1 && $urandom_range(0, 1) == 1) || ($urandom_range(0, 9) == 0);
      r_ready_i  = (phase == 0) || (phase == 1 && $urandom_range(0, 1) == 1) || ($urandom_range(0, 9) == 0);
      cycle();
    end
    aw_valid_i = 0; ar_valid_i = 0;
    // Finish any partial W bursts so every accepted write yields its B.
    while (pend.size() > 0) send_w(int'(pend[0].len) + 1 - wbeat);
    drain(30000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
